// File: rtl/seg7_scan_signed.sv
// Time-multiplexed N-digit 7-segment driver: unsigned hex or sign+magnitude display,
// valid/ready capture with commit deferred to the frame boundary.
module seg7_scan_signed #(
  parameter int N_DIGITS    = 4,
  parameter int DATA_W      = 12,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   num_in,
  input  logic                signed_i,
  input  logic                blank_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [6:0]          seg_o,
  output logic [N_DIGITS-1:0] an_o,
  output logic                frame_o
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(N_DIGITS);
  localparam int MW = 4 * N_DIGITS;

  if (4 * (N_DIGITS - 1) < DATA_W) begin : g_width_check
    $error("seg7_scan_signed: DATA_W does not fit in N_DIGITS-1 digits");
  end

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
    endcase
  endfunction

  logic [TW-1:0]       tick;
  logic [DW-1:0]       dig;
  logic [DATA_W-1:0]   pend_num, disp_num;
  logic                pend_signed, pend_blank, pend_full;
  logic                disp_signed, disp_blank;
  logic                tick_last, frame_end, accept;

  logic                neg;
  logic [DATA_W-1:0]   mag_n;
  logic [MW-1:0]       mag;
  logic [3:0]          nib;
  logic [DW-1:0]       hi;
  logic [6:0]          seg_next;
  logic [N_DIGITS-1:0] an_next;

  assign tick_last = (tick == TW'(REFRESH_DIV - 1));
  assign frame_end = tick_last && (dig == DW'(N_DIGITS - 1));
  assign frame_o   = frame_end;
  assign ready_o   = !pend_full;
  assign accept    = valid_i && !pend_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick        <= '0;
      dig         <= '0;
      pend_full   <= 1'b0;
      pend_num    <= '0;
      pend_signed <= 1'b0;
      pend_blank  <= 1'b0;
      disp_num    <= '0;
      disp_signed <= 1'b0;
      disp_blank  <= 1'b0;
      seg_o       <= '1;
      an_o        <= '1;
    end else begin
      if (tick_last) begin
        tick <= '0;
        dig  <= (dig == DW'(N_DIGITS - 1)) ? '0 : dig + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
      // Capture and commit never coincide: capture needs the pending slot empty.
      if (accept) begin
        pend_num    <= num_in;
        pend_signed <= signed_i;
        pend_blank  <= blank_i;
        pend_full   <= 1'b1;
      end else if (frame_end && pend_full) begin
        disp_num    <= pend_num;
        disp_signed <= pend_signed;
        disp_blank  <= pend_blank;
        pend_full   <= 1'b0;
      end
      seg_o <= seg_next;
      an_o  <= an_next;
    end
  end

  always_comb begin
    neg     = disp_signed & disp_num[DATA_W-1];
    mag_n   = neg ? (~disp_num + 1'b1) : disp_num;
    mag     = MW'(mag_n);
    hi      = '0;
    nib     = mag[3:0];
    an_next = '1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (i > 0 && mag[4*i +: 4] != 4'h0) hi = DW'(i);
      if (dig == DW'(i)) begin
        nib        = mag[4*i +: 4];
        an_next[i] = 1'b0;
      end
    end
    seg_next = hex_seg(nib);
    // The sign position overrides both the nibble and leading-zero blanking.
    if (disp_signed && dig == DW'(N_DIGITS - 1)) seg_next = neg ? 7'h3F : 7'h7F;
    else if (disp_blank && dig > hi)              seg_next = 7'h7F;
  end

endmodule

// File: tb/tb_seg7_scan_signed.sv
// Scoreboard bench for seg7_scan_signed: accepted values queue their expected digit pattern,
// a frame-level reference model commits them and checks every cycle of the scan.
module tb_seg7_scan_signed;

  localparam int ND = 4;
  localparam int DW = 12;
  localparam int RD = 4;
  localparam int NR = ND * RD;

  typedef logic [ND-1:0][6:0] pat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] num_in;
  logic          signed_i, blank_i, valid_i;
  logic          ready_o;
  logic [6:0]    seg_o;
  logic [ND-1:0] an_o;
  logic          frame_o;

  seg7_scan_signed #(.N_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .num_in(num_in), .signed_i(signed_i), .blank_i(blank_i),
    .valid_i(valid_i), .ready_o(ready_o), .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  pat_t exp_q[$];
  pat_t cur_pat, lag_pat;
  int   cyc = 0;
  int   lag_dig = 0;
  bit   lag_rst = 1'b1;
  bit   m_pend = 1'b0;
  bit   started = 1'b0;

  function automatic logic [6:0] ref_seg(input int unsigned n);
    case (n)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic pat_t ref_pat(input int unsigned num, input bit sgn, input bit blk);
    pat_t        p;
    bit          neg;
    int unsigned mag, hi, nib;
    neg = sgn && (num >= (1 << (DW - 1)));
    mag = neg ? ((1 << DW) - num) : num;
    hi  = 0;
    for (int i = 0; i < ND; i++)
      if (((mag >> (4 * i)) & 15) != 0) hi = i;
    for (int i = 0; i < ND; i++) begin
      nib = (mag >> (4 * i)) & 15;
      if (sgn && i == ND - 1) p[i] = neg ? 7'h3F : 7'h7F;
      else if (blk && i > hi) p[i] = 7'h7F;
      else                    p[i] = ref_seg(nib);
    end
    return p;
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: frame position from elapsed cycles, commit pops the scoreboard.
  always @(posedge clk) begin
    bit old;
    int p;
    started = 1'b1;
    if (!rst_n) begin
      cyc = 0; m_pend = 1'b0; lag_rst = 1'b1;
      exp_q.delete();
      cur_pat = ref_pat(0, 1'b0, 1'b0);
    end else begin
      p       = cyc % NR;
      lag_rst = 1'b0;
      lag_dig = p / RD;
      lag_pat = cur_pat;
      old     = m_pend;
      if (p == NR - 1 && old) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
        else cur_pat = exp_q.pop_front();
        m_pend = 1'b0;
      end
      if (valid_i && !old) m_pend = 1'b1;
      cyc++;
    end
  end

  // Monitor: compares presented outputs every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [6:0]    es;
    logic [ND-1:0] ea;
    if (started) begin
      es = lag_rst ? 7'h7F : lag_pat[lag_dig];
      ea = '1;
      if (!lag_rst) ea[lag_dig] = 1'b0;
      check("seg_o", int'(seg_o), int'(es));
      check("an_o", int'(an_o), int'(ea));
      check("ready_o", int'(ready_o), int'(!m_pend));
      check("frame_o", int'(frame_o), int'((cyc % NR) == NR - 1));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] n, input bit s, input bit b);
    @(negedge clk);
    num_in = n; signed_i = s; blank_i = b; valid_i = 1'b1;
    if (!m_pend) exp_q.push_back(ref_pat(n, s, b));
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 4 * NR && m_pend; k++) @(negedge clk);
    if (m_pend) check("idle_timeout", 0, 1);
  endtask

  task automatic show(input logic [DW-1:0] n, input bit s, input bit b);
    wait_idle();
    send(n, s, b);
    wait_idle();
    run(NR + 2);
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; num_in = '0; signed_i = 1'b0; blank_i = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2 * NR);

    show(12'hA3C, 1'b0, 1'b0);
    show(12'hFFD, 1'b1, 1'b0);
    show(12'hFFD, 1'b1, 1'b1);
    show(12'h800, 1'b1, 1'b0);
    show(12'h7FF, 1'b1, 1'b0);
    show(12'h000, 1'b0, 1'b1);
    show(12'h005, 1'b1, 1'b1);

    // Second value while one is pending must be dropped.
    wait_idle();
    send(12'h123, 1'b0, 1'b0);
    send(12'h456, 1'b1, 1'b1);
    wait_idle();
    run(NR + 2);

    // Capture on the boundary cycle commits one frame later.
    begin
      int k;
      for (k = 0; k < 4 * NR && !(!m_pend && (cyc % NR) == NR - 1); k++) @(negedge clk);
      if (k == 4 * NR) check("boundary_timeout", 0, 1);
      num_in = 12'hBEE; signed_i = 1'b0; blank_i = 1'b0; valid_i = 1'b1;
      exp_q.push_back(ref_pat(12'hBEE, 1'b0, 1'b0));
      @(negedge clk);
      valid_i = 1'b0;
      run(2 * NR + 2);
    end

    for (int i = 0; i < 25; i++) begin
      send(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1)
        send(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run($urandom_range(0, 2 * NR));
    end
    wait_idle();
    run(NR + 2);

    // Reset mid-frame with a value pending.
    show(12'h321, 1'b0, 1'b0);
    send(12'h9AB, 1'b1, 1'b0);
    run(3);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(2 * NR + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
